ddr3_read_arbiter: RTL and testbench
====================================

Name: ddr3_read_arbiter

Overview:
Shares the single-beat Avalon-MM DDR3 read port among NUM_REQ block-reader masters, such as coordinate-block readers for separate lens/eye pipelines.
- Arbitration is round-robin.
- Each accepted read is tagged with its requester index in an in-order tag FIFO.
- Each returned readdatavalid beat is routed back to the requester that issued it.
- Sits between the reader instances and the DDR3 controller port, in the ddr3_clk domain.

Parameters:
NUM_REQ, 2, number of requesting read masters (2..8)
MAX_OUTSTANDING, 8, max accepted-but-unreturned reads; tag FIFO depth (power of 2, 2..32)
ADDR_W, 27, DDR3 word address width

Ports:
ddr3_clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
req_address  in  NUM_REQ*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W]
req_read  in  NUM_REQ  per-requester read strobe; held until its waitrequest is low
req_waitrequest  out  NUM_REQ  per-requester waitrequest
req_readdata  out  256  broadcast of ddr3_readdata
req_readdatavalid  out  NUM_REQ  one-hot return strobe
ddr3_address  out  ADDR_W  to controller
ddr3_read  out  1  to controller
ddr3_waitrequest  in  1  from controller
ddr3_readdata  in  256  from controller
ddr3_readdatavalid  in  1  from controller
protocol_error  out  1  sticky: a beat returned with the tag FIFO empty

Behaviour:
Interface rules
- One clock (ddr3_clk); reset is synchronous and active-high.
- Reset values: state=ST_ARB, req_waitrequest all 1, ddr3_read 0, ddr3_address 0, req_readdatavalid 0, protocol_error 0, tag FIFO empty, outstanding count 0, rr pointer 0.

State machine
- ST_ARB: arbitrates only when outstanding count < MAX_OUTSTANDING.
  - Search starts at index rr_ptr+1 mod NUM_REQ and wraps; the first i with req_read[i]=1 wins.
  - On a win, register grant=i and ddr3_address=req_address[i], then go to ST_ISSUE.
  - No request, or outstanding count full: stay in ST_ARB.
- ST_ISSUE: ddr3_read=1, ddr3_address held stable; req_waitrequest[grant]=ddr3_waitrequest, all others 1.
  - When ddr3_waitrequest=0 (accept): push grant into the tag FIFO, increment the count, set rr_ptr=grant, go to ST_ARB.
- ddr3_read is never asserted outside ST_ISSUE.
- Minimum issue spacing is 2 cycles (one arbitration bubble). Grant-to-ddr3_read latency is 1 cycle.

Return path
- When ddr3_readdatavalid=1, pop the tag FIFO and assert req_readdatavalid[tag] combinationally in the same cycle. req_readdata is the direct wire of ddr3_readdata.
- Returns are in order; the controller guarantees this.

Boundary conditions
- Accept and return in the same cycle: push and pop both occur and the count is unchanged.
- Outstanding count = MAX_OUTSTANDING: no new grant. Arbitration resumes in the cycle after a pop makes the count < MAX.
- readdatavalid with the tag FIFO empty: set protocol_error (sticky until reset), drive no req_readdatavalid, leave the count unchanged.
- A requester that drops req_read while granted is a protocol violation. The transfer still completes, because ddr3_read is held by state, not by req_read.
- Reset mid-operation: FIFO flushed, state returns to ST_ARB. Controller beats arriving after reset set protocol_error. The system resets the controller together with this block.
- Single active requester: it is granted every 2 cycles with no starvation. With all NUM_REQ active, grants rotate 0,1,...,NUM_REQ-1.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds output grant_count [NUM_REQ*32] and output stall_count [32].
  - grant_count[i] increments on each accept for requester i.
  - stall_count increments each cycle in ST_ARB where any req_read=1 but the count is at MAX_OUTSTANDING.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset -> req_waitrequest=2'b11, ddr3_read=0, protocol_error=0.
2. Only req 0 reads addr 0x0001040, ddr3_waitrequest=0, data returned 5 cycles later -> ddr3_address=0x0001040 one cycle after req_read, req_readdatavalid=2'b01 with req_readdata=ddr3_readdata.
3. Both requesters read continuously, no waitrequest -> accepts alternate 1,0,1,0 (rr_ptr=0 after reset); returns routed 2'b10,2'b01,... in issue order.
4. Controller holds ddr3_waitrequest=1 for 4 cycles during a grant to req 1 -> ddr3_address stable, req_waitrequest[1] tracks it, req_waitrequest[0]=1 throughout; exactly one tag pushed.
5. MAX_OUTSTANDING=8, no returns -> exactly 8 accepts, then ddr3_read stays 0; a single return enables a 9th accept.
6. ddr3_readdatavalid pulse with nothing outstanding -> protocol_error=1 and stays 1, req_readdatavalid=0; with ARB_PERF_CNT_EN, scenario 3 after 10 accepts gives grant_count = 5/5.

Source files
------------

// File: rtl/ddr3_read_arbiter.sv
// Round-robin arbiter sharing one single-beat Avalon-MM DDR3 read port, with an
// in-order tag FIFO that routes returned beats. Optional counters: ARB_PERF_CNT_EN.
module ddr3_read_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 8,
   parameter int ADDR_W          = 27
) (
   input  logic                      ddr3_clk,
   input  logic                      reset,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ-1:0]        req_read,
   output logic [NUM_REQ-1:0]        req_waitrequest,
   output logic [255:0]              req_readdata,
   output logic [NUM_REQ-1:0]        req_readdatavalid,
   output logic [ADDR_W-1:0]         ddr3_address,
   output logic                      ddr3_read,
   input  logic                      ddr3_waitrequest,
   input  logic [255:0]              ddr3_readdata,
   input  logic                      ddr3_readdatavalid,
   output logic                      protocol_error
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ*32-1:0]     grant_count,
   output logic [31:0]               stall_count
`endif
);

   // state    | meaning
   // ST_ARB   | pick next requester (round-robin) if a tag slot is free
   // ST_ISSUE | ddr3_read driven for the granted requester until accepted

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = PW + 1;

   typedef enum logic {ST_ARB = 1'b0, ST_ISSUE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     rr_q, rr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              perr_q, perr_d;
   logic [GW-1:0]     tag_mem [MAX_OUTSTANDING];

   logic              win_found;
   logic [GW-1:0]     win_idx;
   logic              can_arb;
   logic              fifo_empty;
   logic              accept;
   logic              pop;
   logic              take_grant;

   function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return GW'(s);
   endfunction

   // Search starts one past the last accepted requester and wraps.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && req_read[rr_index(rr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_index(rr_q, k);
         end
      end
   end

   assign can_arb    = (count_q < CW'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign accept     = (state_q == ST_ISSUE) && !ddr3_waitrequest;
   assign pop        = ddr3_readdatavalid && !fifo_empty;
   assign take_grant = (state_q == ST_ARB) && can_arb && win_found;

   always_ff @(posedge ddr3_clk) begin
      if (reset) begin
         state_q  <= ST_ARB;
         grant_q  <= '0;
         rr_q     <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         perr_q   <= perr_d;
      end
   end

   // Storage is not reset; the pointers alone define occupancy.
   always_ff @(posedge ddr3_clk) begin
      if (!reset && accept) tag_mem[wr_ptr_q] <= grant_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARB:   if (can_arb && win_found) state_d = ST_ISSUE;
         ST_ISSUE: if (!ddr3_waitrequest) state_d = ST_ARB;
         default:  state_d = ST_ARB;
      endcase
   end

   always_comb begin
      grant_d  = grant_q;
      addr_d   = addr_q;
      rr_d     = rr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      perr_d   = perr_q | (ddr3_readdatavalid && fifo_empty);
      if (take_grant) begin
         grant_d = win_idx;
         addr_d  = req_address[int'(win_idx)*ADDR_W +: ADDR_W];
      end
      if (accept) begin
         rr_d     = grant_q;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      ddr3_read         = (state_q == ST_ISSUE);
      req_waitrequest   = '1;
      req_readdatavalid = '0;
      if (state_q == ST_ISSUE) req_waitrequest[grant_q] = ddr3_waitrequest;
      if (pop) req_readdatavalid[tag_mem[rd_ptr_q]] = 1'b1;
   end

   assign ddr3_address   = addr_q;
   assign req_readdata   = ddr3_readdata;
   assign protocol_error = perr_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] gcnt_q [NUM_REQ];
   logic [31:0] stall_q;

   always_ff @(posedge ddr3_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
         stall_q <= '0;
      end else begin
         if (accept) gcnt_q[grant_q] <= gcnt_q[grant_q] + 32'd1;
         if ((state_q == ST_ARB) && (|req_read) && !can_arb) stall_q <= stall_q + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
      assign grant_count[g*32 +: 32] = gcnt_q[g];
   end
   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// Self-checking bench for ddr3_read_arbiter: transaction-level reference model
// (queue of outstanding tags) compared every cycle, plus directed scenarios.
module tb_ddr3_read_arbiter;
   localparam int NR  = 2;
   localparam int MAX = 8;
   localparam int AW  = 27;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR*AW-1:0] req_address;
   logic [NR-1:0]    req_read;
   logic [NR-1:0]    req_waitrequest;
   logic [255:0]     req_readdata;
   logic [NR-1:0]    req_readdatavalid;
   logic [AW-1:0]    ddr3_address;
   logic             ddr3_read;
   logic             ddr3_waitrequest;
   logic [255:0]     ddr3_readdata;
   logic             ddr3_readdatavalid;
   logic             protocol_error;
`ifdef ARB_PERF_CNT_EN
   logic [NR*32-1:0] grant_count;
   logic [31:0]      stall_count;
`endif

   always #5 clk = ~clk;

   ddr3_read_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAX), .ADDR_W(AW)) dut (
      .ddr3_clk(clk), .reset(reset),
      .req_address(req_address), .req_read(req_read),
      .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
      .req_readdatavalid(req_readdatavalid),
      .ddr3_address(ddr3_address), .ddr3_read(ddr3_read),
      .ddr3_waitrequest(ddr3_waitrequest), .ddr3_readdata(ddr3_readdata),
      .ddr3_readdatavalid(ddr3_readdatavalid), .protocol_error(protocol_error)
`ifdef ARB_PERF_CNT_EN
      , .grant_count(grant_count), .stall_count(stall_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   // reference model: what the arbiter should hold, in transaction terms
   bit            m_issue;
   int            m_grant;
   logic [AW-1:0] m_addr;
   int            m_rr;
   int            m_tags[$];
   bit            m_perr;
   int unsigned   m_gcnt[NR];
   int unsigned   m_stall;

   bit [NR-1:0]   keep_req;
   int            acc_log[$];
   logic [NR-1:0] rdv_log[$];

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic model_reset();
      m_issue = 0; m_grant = 0; m_addr = '0; m_rr = 0; m_perr = 0;
      m_tags.delete();
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
      m_stall = 0;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a);
      req_read[i] = 1'b1;
      req_address[i*AW +: AW] = a;
   endtask

   // Inputs are already set (at negedge); compare, advance model, step one clock.
   task automatic cycle();
      logic [NR-1:0] exp_wr, exp_rdv, acc;
      int n0;
      bit found;
      #1;
      if (!reset) begin
         exp_wr = '1;
         if (m_issue) exp_wr[m_grant] = ddr3_waitrequest;
         exp_rdv = '0;
         if (ddr3_readdatavalid && m_tags.size() > 0) exp_rdv[m_tags[0]] = 1'b1;
         checks++;
         if (ddr3_read !== m_issue) begin errors++; $display("FAIL ddr3_read got=%b exp=%b t=%0t", ddr3_read, m_issue, $time); end
         checks++;
         if (ddr3_address !== m_addr) begin errors++; $display("FAIL ddr3_address got=%h exp=%h t=%0t", ddr3_address, m_addr, $time); end
         checks++;
         if (req_waitrequest !== exp_wr) begin errors++; $display("FAIL req_waitrequest got=%b exp=%b t=%0t", req_waitrequest, exp_wr, $time); end
         checks++;
         if (req_readdatavalid !== exp_rdv) begin errors++; $display("FAIL req_readdatavalid got=%b exp=%b t=%0t", req_readdatavalid, exp_rdv, $time); end
         checks++;
         if (req_readdata !== ddr3_readdata) begin errors++; $display("FAIL req_readdata got=%h exp=%h", req_readdata[31:0], ddr3_readdata[31:0]); end
         checks++;
         if (protocol_error !== m_perr) begin errors++; $display("FAIL protocol_error got=%b exp=%b t=%0t", protocol_error, m_perr, $time); end
`ifdef ARB_PERF_CNT_EN
         for (int i = 0; i < NR; i++) begin
            checks++;
            if (grant_count[i*32 +: 32] !== m_gcnt[i]) begin errors++; $display("FAIL grant_count[%0d] got=%0d exp=%0d", i, grant_count[i*32 +: 32], m_gcnt[i]); end
         end
         checks++;
         if (stall_count !== m_stall) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", stall_count, m_stall); end
`endif
      end
      acc = req_read & ~req_waitrequest;
      for (int i = 0; i < NR; i++) if (acc[i] && ddr3_read && !reset) acc_log.push_back(i);
      if (|req_readdatavalid && !reset) rdv_log.push_back(req_readdatavalid);
      if (reset) model_reset();
      else begin
         n0 = m_tags.size();
         if (ddr3_readdatavalid) begin
            if (n0 > 0) void'(m_tags.pop_front());
            else m_perr = 1;
         end
         if (m_issue) begin
            if (!ddr3_waitrequest) begin
               m_tags.push_back(m_grant);
               m_gcnt[m_grant]++;
               m_rr = m_grant;
               m_issue = 0;
            end
         end else if (n0 < MAX) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
               if (!found && req_read[(m_rr + k) % NR]) begin
                  found = 1;
                  m_issue = 1;
                  m_grant = (m_rr + k) % NR;
                  m_addr = req_address[m_grant*AW +: AW];
               end
            end
         end else if (|req_read) m_stall++;
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) begin
            if (keep_req[i]) req_address[i*AW +: AW] = AW'($urandom());
            else req_read[i] = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1; req_read = '0; keep_req = '0;
      ddr3_readdatavalid = 0; ddr3_waitrequest = 0;
      cycle(); cycle();
      reset = 0;
      acc_log.delete(); rdv_log.delete();
   endtask

   task automatic drain();
      bit done;
      done = 0;
      keep_req = '0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (m_tags.size() == 0 && !m_issue && req_read == '0) done = 1;
         else begin
            ddr3_waitrequest = 0;
            ddr3_readdatavalid = (m_tags.size() > 0);
            ddr3_readdata = rand256();
            cycle();
         end
      end
      ddr3_readdatavalid = 0;
      checks++;
      if (!done) begin errors++; $display("FAIL drain_timeout got=%0d exp=0 outstanding", m_tags.size()); end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (req_waitrequest !== 2'b11) begin errors++; $display("FAIL reset_waitreq got=%b exp=11", req_waitrequest); end
      checks++;
      if (ddr3_read !== 1'b0 || protocol_error !== 1'b0 || req_readdatavalid !== '0 || ddr3_address !== '0) begin
         errors++; $display("FAIL reset_outputs got=%b%b%b%h exp=000000", ddr3_read, protocol_error, req_readdatavalid, ddr3_address);
      end
   endtask

   task automatic test_single();
      logic [255:0] d;
      do_reset();
      set_req(0, 27'h0001040);
      cycle();
      #1;
      checks++;
      if (ddr3_address !== 27'h0001040 || ddr3_read !== 1'b1) begin
         errors++; $display("FAIL single_issue got=%h/%b exp=0001040/1", ddr3_address, ddr3_read);
      end
      cycle();
      for (int c = 0; c < 4; c++) cycle();
      d = rand256();
      ddr3_readdata = d; ddr3_readdatavalid = 1;
      #1;
      checks++;
      if (req_readdatavalid !== 2'b01 || req_readdata !== d) begin
         errors++; $display("FAIL single_return got=%b exp=01", req_readdatavalid);
      end
      cycle();
      ddr3_readdatavalid = 0;
      cycle();
   endtask

   task automatic test_alternate();
      bit hit10;
      hit10 = 0;
      do_reset();
      keep_req = 2'b11;
      set_req(0, AW'($urandom())); set_req(1, AW'($urandom()));
      for (int c = 0; c < 200 && !hit10; c++) begin
         ddr3_readdatavalid = (m_tags.size() >= 3);
         ddr3_readdata = rand256();
         cycle();
         if (acc_log.size() >= 10) begin
            hit10 = 1;
`ifdef ARB_PERF_CNT_EN
            checks++;
            if (grant_count !== {32'd5, 32'd5}) begin errors++; $display("FAIL perf_grant got=%h exp=5/5", grant_count); end
`endif
         end
      end
      ddr3_readdatavalid = 0;
      checks++;
      if (!hit10) begin errors++; $display("FAIL alt_timeout got=%0d exp=10 accepts", acc_log.size()); end
      drain();
      for (int i = 0; i < 10 && i < acc_log.size(); i++) begin
         checks++;
         if (acc_log[i] !== ((i % 2 == 0) ? 1 : 0)) begin errors++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", i, acc_log[i], (i % 2 == 0) ? 1 : 0); end
      end
      for (int i = 0; i < 10 && i < rdv_log.size(); i++) begin
         checks++;
         if (rdv_log[i] !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_return[%0d] got=%b", i, rdv_log[i]); end
      end
   endtask

   task automatic test_wait();
      logic [AW-1:0] a;
      do_reset();
      a = AW'($urandom());
      set_req(1, a);
      ddr3_waitrequest = 1;
      cycle();
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (ddr3_address !== a || req_waitrequest !== 2'b11 || ddr3_read !== 1'b1) begin
            errors++; $display("FAIL wait_hold got=%h/%b exp=%h/11", ddr3_address, req_waitrequest, a);
         end
         cycle();
      end
      ddr3_waitrequest = 0;
      #1;
      checks++;
      if (req_waitrequest !== 2'b01) begin errors++; $display("FAIL wait_release got=%b exp=01", req_waitrequest); end
      cycle();
      cycle();
      checks++;
      if (acc_log.size() !== 1) begin errors++; $display("FAIL wait_tags got=%0d exp=1", acc_log.size()); end
      drain();
      checks++;
      if (rdv_log.size() !== 1 || rdv_log[0] !== 2'b10) begin errors++; $display("FAIL wait_return got=%0d exp=1 beat to req1", rdv_log.size()); end
   endtask

   task automatic test_full();
      bit ninth;
      ninth = 0;
      do_reset();
      keep_req = 2'b01;
      set_req(0, AW'($urandom()));
      for (int c = 0; c < 40; c++) cycle();
      #1;
      checks++;
      if (acc_log.size() !== MAX) begin errors++; $display("FAIL full_count got=%0d exp=%0d", acc_log.size(), MAX); end
      checks++;
      if (ddr3_read !== 1'b0) begin errors++; $display("FAIL full_noread got=%b exp=0", ddr3_read); end
      keep_req = '0;
      ddr3_readdatavalid = 1; ddr3_readdata = rand256();
      cycle();
      ddr3_readdatavalid = 0;
      for (int c = 0; c < 6 && !ninth; c++) begin
         cycle();
         if (acc_log.size() == MAX + 1) ninth = 1;
      end
      checks++;
      if (!ninth) begin errors++; $display("FAIL full_ninth got=%0d exp=%0d", acc_log.size(), MAX + 1); end
      drain();
   endtask

   task automatic test_perr();
      ddr3_readdatavalid = 1; ddr3_readdata = rand256();
      #1;
      checks++;
      if (req_readdatavalid !== 2'b00) begin errors++; $display("FAIL perr_rdv got=%b exp=00", req_readdatavalid); end
      cycle();
      ddr3_readdatavalid = 0;
      for (int c = 0; c < 3; c++) cycle();
      checks++;
      if (protocol_error !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", protocol_error); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      keep_req = 2'b11;
      set_req(0, AW'($urandom())); set_req(1, AW'($urandom()));
      for (int c = 0; c < 8; c++) cycle();
      do_reset();
      ddr3_readdatavalid = 1;
      cycle();
      ddr3_readdatavalid = 0;
      cycle();
      checks++;
      if (protocol_error !== 1'b1) begin errors++; $display("FAIL reset_mid_perr got=%b exp=1", protocol_error); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NR; i++)
            if (!req_read[i] && ($urandom() % 3 == 0)) set_req(i, AW'($urandom()));
         ddr3_waitrequest   = ($urandom() % 3 == 0);
         ddr3_readdatavalid = (m_tags.size() > 0) && ($urandom() % 4 == 0);
         ddr3_readdata      = rand256();
         cycle();
      end
      drain();
   endtask

   initial begin
      reset = 1; req_read = '0; req_address = '0; keep_req = '0;
      ddr3_waitrequest = 0; ddr3_readdata = '0; ddr3_readdatavalid = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single();
      test_alternate();
      test_wait();
      test_full();
      test_perr();
      test_random();
      test_reset_mid();
      test_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
